// File: rtl/gol_board_buffer_if.sv
// Bus bundle between the Game of Life controller/update logic and gol_board_buffer:
// read window, row writes, seed loads and the swap handshake.
interface gol_board_buffer_if #(
  parameter int WIDTH   = 8,
  parameter int REGBITS = 3,
  parameter int GENBITS = 16
);
  logic [REGBITS-1:0] ra;
  logic [WIDTH-1:0]   rd_n;
  logic [WIDTH-1:0]   rd_c;
  logic [WIDTH-1:0]   rd_s;
  logic               regwrite;
  logic [REGBITS-1:0] wa;
  logic [WIDTH-1:0]   wd;
  logic               load;
  logic               swap;
  logic               swap_err;
  logic               stable;
  logic [GENBITS-1:0] generation;

  modport master (
    output ra, regwrite, wa, wd, load, swap,
    input  rd_n, rd_c, rd_s, swap_err, stable, generation
  );

  modport slave (
    input  ra, regwrite, wa, wd, load, swap,
    output rd_n, rd_c, rd_s, swap_err, stable, generation
  );
endinterface

// File: rtl/gol_board_buffer.sv
// Double-buffered Game of Life board store with a north/centre/south read window.
// Define GOL_TORUS_EN for vertical wrap-around; otherwise rows beyond the edges read as dead.
module gol_board_buffer #(
  parameter int WIDTH   = 8,
  parameter int REGBITS = 3,
  parameter int GENBITS = 16
) (
  input logic               ph2,
  input logic               reset,
  gol_board_buffer_if.slave bus
);
  localparam int DEPTH = 2 ** REGBITS;

  logic [WIDTH-1:0]   mem [2][DEPTH];
  logic               bank_sel;
  logic [DEPTH-1:0]   written_mask;
  logic               changed;
  logic [GENBITS-1:0] generation;
  logic               stable;
  logic               swap_err;

  logic               wr_fire;
  logic [DEPTH-1:0]   wr_bit;
  logic               wr_change;
  logic               swap_ok;
  logic               swap_rej;
  logic [REGBITS-1:0] ra_n;
  logic [REGBITS-1:0] ra_s;

  always_comb begin
    wr_fire   = bus.regwrite & ~bus.load;
    wr_bit    = '0;
    if (wr_fire) wr_bit[bus.wa] = 1'b1;
    wr_change = wr_fire && (bus.wd != mem[bank_sel][bus.wa]);
    // The write landing this same cycle counts toward completing the mask.
    swap_ok   = bus.swap & ~bus.load & (&(written_mask | wr_bit));
    swap_rej  = bus.swap & ~swap_ok;
  end

  assign ra_n = bus.ra - REGBITS'(1);
  assign ra_s = bus.ra + REGBITS'(1);

  assign bus.rd_c = mem[bank_sel][bus.ra];
`ifdef GOL_TORUS_EN
  assign bus.rd_n = mem[bank_sel][ra_n];
  assign bus.rd_s = mem[bank_sel][ra_s];
`else
  assign bus.rd_n = (bus.ra == '0) ? '0 : mem[bank_sel][ra_n];
  assign bus.rd_s = (&bus.ra)      ? '0 : mem[bank_sel][ra_s];
`endif

  assign bus.generation = generation;
  assign bus.stable     = stable;
  assign bus.swap_err   = swap_err;

  always_ff @(posedge ph2) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) begin
        mem[0][r] <= '0;
        mem[1][r] <= '0;
      end
      bank_sel     <= 1'b0;
      written_mask <= '0;
      changed      <= 1'b0;
      generation   <= '0;
      stable       <= 1'b0;
      swap_err     <= 1'b0;
    end else begin
      swap_err <= swap_rej;
      if (bus.load)
        mem[bank_sel][bus.wa] <= bus.wd;
      else if (bus.regwrite)
        mem[~bank_sel][bus.wa] <= bus.wd;

      if (swap_ok) begin
        bank_sel     <= ~bank_sel;
        generation   <= generation + GENBITS'(1);
        stable       <= ~(changed | wr_change);
        written_mask <= '0;
        changed      <= 1'b0;
      end else begin
        written_mask <= written_mask | wr_bit;
        if (wr_change) changed <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_gol_board_buffer.sv
// Directed bench for gol_board_buffer: seed loads, read window edges, swap accept/reject,
// mid-generation reset and generation wrap on a narrow-counter instance.
module tb_gol_board_buffer;
  logic ph2 = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] cur [8];

  always #5 ph2 = ~ph2;

  gol_board_buffer_if #(.WIDTH(8), .REGBITS(3), .GENBITS(16)) bus ();
  gol_board_buffer_if #(.WIDTH(8), .REGBITS(3), .GENBITS(2))  bus2 ();

  gol_board_buffer #(.WIDTH(8), .REGBITS(3), .GENBITS(16)) dut (
    .ph2(ph2), .reset(reset), .bus(bus.slave));
  gol_board_buffer #(.WIDTH(8), .REGBITS(3), .GENBITS(2)) dut2 (
    .ph2(ph2), .reset(reset), .bus(bus2.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ph2);
    #1;
  endtask

  task automatic load_row(input int r, input logic [7:0] d);
    bus.load = 1'b1; bus.wa = 3'(r); bus.wd = d;
    step();
    bus.load = 1'b0;
    cur[r] = d;
  endtask

  task automatic write_row(input int r, input logic [7:0] d);
    bus.regwrite = 1'b1; bus.wa = 3'(r); bus.wd = d;
    step();
    bus.regwrite = 1'b0;
  endtask

  task automatic do_swap();
    bus.swap = 1'b1;
    step();
    bus.swap = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.ra = '0; bus.regwrite = 0; bus.wa = '0; bus.wd = '0; bus.load = 0; bus.swap = 0;
    bus2.ra = '0; bus2.regwrite = 0; bus2.wa = '0; bus2.wd = '0; bus2.load = 0; bus2.swap = 0;
    for (int i = 0; i < 8; i++) cur[i] = 8'h00;
    step(); step();
    reset = 1'b0;
    check("reset_rd_c", bus.rd_c, 8'h00);
    check("reset_gen", bus.generation, 0);
    check("reset_stable", bus.stable, 0);
    check("reset_swap_err", bus.swap_err, 0);

    // Seed rows 0..2 into the current bank
    load_row(0, 8'h18);
    load_row(1, 8'h30);
    load_row(2, 8'h10);
    bus.ra = 3'd1; #1;
    check("seed_rd_n", bus.rd_n, 8'h18);
    check("seed_rd_c", bus.rd_c, 8'h30);
    check("seed_rd_s", bus.rd_s, 8'h10);
    check("seed_gen", bus.generation, 0);

    bus.ra = 3'd0; #1;
    check("top_rd_n", bus.rd_n, 8'h00);
    check("top_rd_c", bus.rd_c, 8'h18);
    check("top_rd_s", bus.rd_s, 8'h30);

    load_row(7, 8'hFF);
    bus.ra = 3'd0; #1;
`ifdef GOL_TORUS_EN
    check("edge_rd_n_row0", bus.rd_n, 8'hFF);
`else
    check("edge_rd_n_row0", bus.rd_n, 8'h00);
`endif
    bus.ra = 3'd7; #1;
    check("edge_rd_c_row7", bus.rd_c, 8'hFF);
`ifdef GOL_TORUS_EN
    check("edge_rd_s_row7", bus.rd_s, 8'h18);
`else
    check("edge_rd_s_row7", bus.rd_s, 8'h00);
`endif
    check("edge_rd_n_row7", bus.rd_n, 8'h00);

    // Incomplete mask: rows 0..6 only
    for (int i = 0; i < 7; i++) write_row(i, cur[i]);
    do_swap();
    check("rej_swap_err", bus.swap_err, 1);
    check("rej_gen", bus.generation, 0);
    bus.ra = 3'd1; #1;
    check("rej_rd_c", bus.rd_c, 8'h30);
    step();
    check("rej_err_one_cycle", bus.swap_err, 0);

    // Load with swap is always rejected; load lands in current bank
    bus.load = 1'b1; bus.swap = 1'b1; bus.wa = 3'd5; bus.wd = 8'h42;
    step();
    bus.load = 1'b0; bus.swap = 1'b0;
    cur[5] = 8'h42;
    check("load_swap_err", bus.swap_err, 1);
    check("load_swap_gen", bus.generation, 0);
    bus.ra = 3'd5; #1;
    check("load_swap_rd_c", bus.rd_c, 8'h42);

    // Full identical board -> stable
    for (int i = 0; i < 8; i++) write_row(i, cur[i]);
    do_swap();
    check("sw1_gen", bus.generation, 1);
    check("sw1_stable", bus.stable, 1);
    check("sw1_swap_err", bus.swap_err, 0);
    bus.ra = 3'd5; #1;
    check("sw1_rd_c", bus.rd_c, 8'h42);

    // Row 3 changed, written in the same cycle as swap
    for (int i = 0; i < 8; i++) if (i != 3) write_row(i, cur[i]);
    bus.regwrite = 1'b1; bus.wa = 3'd3; bus.wd = 8'h3C; bus.swap = 1'b1;
    step();
    bus.regwrite = 1'b0; bus.swap = 1'b0;
    cur[3] = 8'h3C;
    bus.ra = 3'd3; #1;
    check("sw2_rd_c", bus.rd_c, 8'h3C);
    check("sw2_rd_n", bus.rd_n, 8'h10);
    bus.ra = 3'd4; #1;
    check("sw2_rd_n_row4", bus.rd_n, 8'h3C);
    check("sw2_gen", bus.generation, 2);
    check("sw2_stable", bus.stable, 0);

    // Advance to generation 5, then partial mask 0F
    for (int g = 0; g < 3; g++) begin
      for (int i = 0; i < 8; i++) write_row(i, cur[i]);
      do_swap();
    end
    check("gen5", bus.generation, 5);
    check("gen5_stable", bus.stable, 1);
    for (int i = 0; i < 4; i++) write_row(i, 8'hA5);
    reset = 1'b1;
    bus.swap = 1'b1;
    step();
    reset = 1'b0;
    bus.swap = 1'b0;
    bus.ra = 3'd1; #1;
    check("rst_mid_rd_n", bus.rd_n, 8'h00);
    check("rst_mid_rd_c", bus.rd_c, 8'h00);
    check("rst_mid_rd_s", bus.rd_s, 8'h00);
    check("rst_mid_gen", bus.generation, 0);
    check("rst_mid_stable", bus.stable, 0);
    check("rst_mid_swap_err", bus.swap_err, 0);
    do_swap();
    check("rst_mid_swap_rej", bus.swap_err, 1);
    check("rst_mid_swap_gen", bus.generation, 0);

    // Narrow counter: four accepted swaps wrap to 0
    for (int g = 1; g <= 4; g++) begin
      for (int i = 0; i < 8; i++) begin
        bus2.regwrite = 1'b1; bus2.wa = 3'(i); bus2.wd = 8'(g);
        step();
      end
      bus2.regwrite = 1'b0;
      bus2.swap = 1'b1;
      step();
      bus2.swap = 1'b0;
      check($sformatf("wrap_gen_%0d", g), bus2.generation, 32'(g % 4));
    end
    bus2.ra = 3'd2; #1;
    check("wrap_rd_c", bus2.rd_c, 8'h04);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
